lab2_sweep_ctrl: RTL and testbench

LAB2_SWEEP_CTRL -- requirements
Module: lab2_sweep_ctrl

---
 rtl/lab2_pkg.sv | 21 ++
 rtl/lab2_settle_timer.sv | 39 +++
 rtl/lab2_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_lab2_sweep_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab2_pkg.sv
// Shared types and constants for the lab2 sweep controller: FSM encoding,
// vector geometry and the default expected truth table of the unit under test.
package lab2_pkg;

    localparam int VEC_W    = 3;
    localparam int VEC_CNT  = 8;
    localparam int SETTLE_W = 4;
    localparam int ERR_W    = 4;

    localparam logic [VEC_W-1:0]   LAST_VEC  = 3'd7;
    localparam logic [VEC_CNT-1:0] DEF_EXP_X = 8'h49;
    localparam logic [VEC_CNT-1:0] DEF_EXP_Y = 8'hC6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/lab2_settle_timer.sv
// Settle-wait counter: held at zero while load_i is high, counts while count_i
// is high, and flags expire_o during the LIMIT-th counted cycle.
module lab2_settle_timer
    import lab2_pkg::*;
#(
    parameter int unsigned LIMIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);

    localparam logic [SETTLE_W-1:0] LAST_CNT = SETTLE_W'(LIMIT - 1);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    assign expire_o = count_i && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (count_i && !expire_o) begin
            cnt_d = cnt_q + SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lab2_sweep_ctrl.sv
// Exhaustive 3-input sweep of a combinational unit: drives each vector, waits
// SETTLE cycles, captures X/Y, compares against EXP_X/EXP_Y and reports.
module lab2_sweep_ctrl
    import lab2_pkg::*;
#(
    parameter int unsigned         SETTLE = 2,
    parameter logic [VEC_CNT-1:0]  EXP_X  = DEF_EXP_X,
    parameter logic [VEC_CNT-1:0]  EXP_Y  = DEF_EXP_Y
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               x_in,
    input  logic               y_in,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic               fail_valid,
    output logic [VEC_W-1:0]   first_fail,
    output logic [VEC_CNT-1:0] cap_x,
    output logic [VEC_CNT-1:0] cap_y,
    output state_e             state_dbg
);

    state_e             state_q;
    logic [VEC_W-1:0]   vec_q;
    logic               done_q;
    logic               pass_q;
    logic [ERR_W-1:0]   err_cnt_q;
    logic               fail_valid_q;
    logic [VEC_W-1:0]   first_fail_q;
    logic [VEC_CNT-1:0] cap_x_q;
    logic [VEC_CNT-1:0] cap_y_q;

    logic settle_expire;
    logic mismatch;

    lab2_settle_timer #(
        .LIMIT (SETTLE)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (state_q != ST_DRIVE),
        .count_i  (state_q == ST_DRIVE),
        .expire_o (settle_expire)
    );

    assign mismatch = (x_in != EXP_X[vec_q]) || (y_in != EXP_Y[vec_q]);

    // done is raised on the edge that leaves DONE so an abort seen in DONE can
    // still suppress it; the pulse therefore lands in the first IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            cap_x_q      <= '0;
            cap_y_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_q      <= ST_DRIVE;
                        vec_q        <= '0;
                        pass_q       <= 1'b0;
                        err_cnt_q    <= '0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= '0;
                        cap_x_q      <= '0;
                        cap_y_q      <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        pass_q  <= 1'b0;
                    end else if (settle_expire) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        pass_q  <= 1'b0;
                    end else begin
                        cap_x_q[vec_q] <= x_in;
                        cap_y_q[vec_q] <= y_in;
                        if (mismatch) begin
                            err_cnt_q <= err_cnt_q + ERR_W'(1);
                            if (!fail_valid_q) begin
                                fail_valid_q <= 1'b1;
                                first_fail_q <= vec_q;
                            end
                        end
                        if (vec_q == LAST_VEC) begin
                            state_q <= ST_DONE;
                        end else begin
                            vec_q   <= vec_q + VEC_W'(1);
                            state_q <= ST_DRIVE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (abort) begin
                        pass_q <= 1'b0;
                    end else begin
                        done_q <= 1'b1;
                        pass_q <= (err_cnt_q == '0);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign {a, b, c}  = vec_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign fail_valid = fail_valid_q;
    assign first_fail = first_fail_q;
    assign cap_x      = cap_x_q;
    assign cap_y      = cap_y_q;
    assign state_dbg  = state_q;

    // A done pulse can only follow a DONE cycle, and at most one error per vector.
    a_done_from_done_state: assert property (
        @(posedge clk) disable iff (!rst_n) done_q |-> ($past(state_q) == ST_DONE));
    a_err_cnt_bounded: assert property (
        @(posedge clk) disable iff (!rst_n) err_cnt_q <= ERR_W'(VEC_CNT));

endmodule

// File: tb/tb_lab2_sweep_ctrl.sv
// Bench for lab2_sweep_ctrl: table of unit-under-test behaviours, randomized
// responses against a truth-table model, and hand sequences for abort/reset/hold.
module tb_lab2_sweep_ctrl;
    import lab2_pkg::*;

    localparam int          TB_SETTLE = 2;
    localparam int          TB_LAT    = 8 * (TB_SETTLE + 1) + 1;
    localparam logic [7:0]  TB_EXP_X  = 8'h49;
    localparam logic [7:0]  TB_EXP_Y  = 8'hC6;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       x_in;
    logic       y_in;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_cnt;
    logic       fail_valid;
    logic [2:0] first_fail;
    logic [7:0] cap_x;
    logic [7:0] cap_y;
    state_e     state_dbg;

    // Behaviour of the combinational unit being swept, per vector index.
    logic [7:0] uut_x;
    logic [7:0] uut_y;

    int n_cmp;
    int n_fail;
    logic [24:0] exp_q[$];

    typedef struct {
        logic [7:0] rx;
        logic [7:0] ry;
        logic       pass;
        logic       fv;
        logic [2:0] ff;
        logic [3:0] err;
        logic [7:0] cx;
        logic [7:0] cy;
    } vec_row_t;

    vec_row_t rows[7];

    lab2_sweep_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .x_in       (x_in),
        .y_in       (y_in),
        .a          (a),
        .b          (b),
        .c          (c),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .fail_valid (fail_valid),
        .first_fail (first_fail),
        .cap_x      (cap_x),
        .cap_y      (cap_y),
        .state_dbg  (state_dbg)
    );

    assign x_in = uut_x[{a, b, c}];
    assign y_in = uut_y[{a, b, c}];

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: every vector whose X or Y differs from the truth table is an error.
    function automatic logic [24:0] model(input logic [7:0] rx, input logic [7:0] ry);
        int         err;
        logic       fv;
        logic [2:0] ff;
        err = 0;
        fv  = 1'b0;
        ff  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (rx[i] != TB_EXP_X[i] || ry[i] != TB_EXP_Y[i]) begin
                if (!fv) begin
                    fv = 1'b1;
                    ff = 3'(i);
                end
                err++;
            end
        end
        return {(err == 0), fv, ff, 4'(err), rx, ry};
    endfunction

    function automatic logic [2:0] exp_vec(input int off);
        if (off < 8 * (TB_SETTLE + 1)) return 3'(off / (TB_SETTLE + 1));
        return 3'd7;
    endfunction

    // Driver: one start pulse; returns in the first cycle after the sampling edge.
    task automatic start_sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [7:0] rx, input logic [7:0] ry,
                                 input logic [24:0] exp_res);
        int lat;
        int abc_bad;
        exp_q.push_back(exp_res);
        uut_x = rx;
        uut_y = ry;
        start_sweep();
        lat     = -1;
        abc_bad = 0;
        for (int off = 0; off < 200; off++) begin
            if (done) begin
                lat = off;
                break;
            end
            if ({a, b, c} != exp_vec(off)) abc_bad++;
            tick();
        end
        check({tag, ".latency"}, lat, TB_LAT);
        check({tag, ".abc_seq_errs"}, abc_bad, 0);
        check({tag, ".busy_at_done"}, busy, 1'b0);
        check({tag, ".result"}, {pass, fail_valid, first_fail, err_cnt, cap_x, cap_y},
              exp_q.pop_front());
        tick();
        check({tag, ".done_one_cycle"}, done, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".abc"}, {a, b, c}, 3'd0);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".done"}, done, 1'b0);
        check({tag, ".pass"}, pass, 1'b0);
        check({tag, ".err_cnt"}, err_cnt, 4'd0);
        check({tag, ".fail"}, {fail_valid, first_fail}, 4'd0);
        check({tag, ".cap"}, {cap_x, cap_y}, 16'h0000);
        check({tag, ".state"}, state_dbg, ST_IDLE);
    endtask

    initial begin
        int          dones;
        int          first_done;
        int          second_done;
        logic [7:0]  rx;
        logic [7:0]  ry;
        int          mode;
        int          bitn;

        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        uut_x  = TB_EXP_X;
        uut_y  = TB_EXP_Y;

        rows[0] = '{8'h49, 8'hC6, 1'b1, 1'b0, 3'd0, 4'd0, 8'h49, 8'hC6};
        rows[1] = '{8'h00, 8'hC6, 1'b0, 1'b1, 3'd0, 4'd3, 8'h00, 8'hC6};
        rows[2] = '{8'h49, 8'hE6, 1'b0, 1'b1, 3'd5, 4'd1, 8'h49, 8'hE6};
        rows[3] = '{8'hFF, 8'hC6, 1'b0, 1'b1, 3'd1, 4'd5, 8'hFF, 8'hC6};
        rows[4] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 4'd6, 8'h00, 8'h00};
        rows[5] = '{8'hC9, 8'h46, 1'b0, 1'b1, 3'd7, 4'd1, 8'hC9, 8'h46};
        rows[6] = '{8'hB6, 8'h39, 1'b0, 1'b1, 3'd0, 4'd8, 8'hB6, 8'h39};

        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Table: first row starts on the first edge after reset release.
        for (int i = 0; i < 7; i++) begin
            run_and_check($sformatf("row%0d", i), rows[i].rx, rows[i].ry,
                          {rows[i].pass, rows[i].fv, rows[i].ff, rows[i].err,
                           rows[i].cx, rows[i].cy});
        end

        // Randomized unit responses against the model.
        for (int i = 0; i < 12; i++) begin
            mode = $urandom_range(0, 2);
            rx   = TB_EXP_X;
            ry   = TB_EXP_Y;
            if (mode == 0) begin
                rx = 8'($urandom_range(0, 255));
                ry = 8'($urandom_range(0, 255));
            end else if (mode == 2) begin
                bitn = $urandom_range(0, 15);
                if (bitn < 8) rx = rx ^ (8'd1 << bitn);
                else          ry = ry ^ (8'd1 << (bitn - 8));
            end
            run_and_check($sformatf("rand%0d", i), rx, ry, model(rx, ry));
        end

        // Abort during the DRIVE phase of vector 3.
        uut_x = TB_EXP_X;
        uut_y = TB_EXP_Y;
        start_sweep();
        repeat (3 * (TB_SETTLE + 1)) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_drive.busy", busy, 1'b0);
        check("abort_drive.abc_hold", {a, b, c}, 3'd3);
        check("abort_drive.cap", {cap_x, cap_y}, {8'h01, 8'h06});
        check("abort_drive.err_pass", {err_cnt, pass, fail_valid}, 6'd0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) dones++;
            tick();
        end
        check("abort_drive.no_done", dones, 0);
        run_and_check("after_abort", TB_EXP_X, TB_EXP_Y, model(TB_EXP_X, TB_EXP_Y));

        // Abort in SAMPLE of vector 0: the capture of that cycle must not happen.
        uut_x = 8'h00;
        uut_y = 8'hFF;
        start_sweep();
        repeat (TB_SETTLE) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_sample.busy", busy, 1'b0);
        check("abort_sample.cap", {cap_x, cap_y}, 16'h0000);
        check("abort_sample.err", {err_cnt, fail_valid}, 5'd0);

        // Abort in DONE: no done pulse, pass low, results kept.
        uut_x = 8'h00;
        uut_y = TB_EXP_Y;
        start_sweep();
        repeat (8 * (TB_SETTLE + 1)) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done.done", done, 1'b0);
        check("abort_done.pass", pass, 1'b0);
        check("abort_done.busy", busy, 1'b0);
        check("abort_done.kept", {err_cnt, fail_valid, first_fail, cap_x}, {4'd3, 1'b1, 3'd0, 8'h00});
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) dones++;
            tick();
        end
        check("abort_done.no_done", dones, 0);

        // start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle.busy", busy, 1'b0);

        // start held high: back-to-back sweeps with one IDLE cycle between them.
        uut_x = TB_EXP_X;
        uut_y = TB_EXP_Y;
        start = 1'b1;
        tick();
        dones       = 0;
        first_done  = -1;
        second_done = -1;
        for (int off = 1; off <= 3 * (TB_LAT + 1) - 1; off++) begin
            tick();
            if (done) begin
                dones++;
                if (first_done < 0) first_done = off;
                else if (second_done < 0) second_done = off;
            end
        end
        start = 1'b0;
        check("held.done_count", dones, 3);
        check("held.first_done", first_done, TB_LAT);
        check("held.period", second_done - first_done, TB_LAT + 1);
        check("held.pass", pass, 1'b1);
        tick();
        check("held.idle", busy, 1'b0);

        // Asynchronous reset while vector 6 is being driven.
        uut_x = 8'h00;
        uut_y = TB_EXP_Y;
        start_sweep();
        repeat (6 * (TB_SETTLE + 1)) tick();
        check("pre_reset.err", err_cnt, 4'd2);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        tick();
        rst_n = 1'b1;
        run_and_check("after_reset", TB_EXP_X, TB_EXP_Y, model(TB_EXP_X, TB_EXP_Y));

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
